// File: rtl/spi_regfile_peripheral_if.sv
// rtl/spi_regfile_peripheral_if.sv - SPI pin bundle for the register-file peripheral
// Purpose: groups the four-wire SPI pins plus the CIPO output enable.
// Signals:
//   nCS     chip select, active low (controller -> peripheral)
//   SCLK    SPI clock, mode 0 (controller -> peripheral)
//   COPI    controller-out data (controller -> peripheral)
//   CIPO    peripheral-out data (peripheral -> controller)
//   cipo_oe CIPO output enable (peripheral -> pad)
// Modports: master = controller side, slave = peripheral side.
interface spi_regfile_peripheral_if;
  logic nCS;
  logic SCLK;
  logic COPI;
  logic CIPO;
  logic cipo_oe;

  modport master (
    output nCS,
    output SCLK,
    output COPI,
    input  CIPO,
    input  cipo_oe
  );

  modport slave (
    input  nCS,
    input  SCLK,
    input  COPI,
    output CIPO,
    output cipo_oe
  );
endinterface

// File: rtl/spi_regfile_peripheral.sv
// rtl/spi_regfile_peripheral.sv - SPI mode-0 peripheral fronting a small register file
// Purpose: oversamples an asynchronous SPI bus on clk, decodes frames of
//   {R/W, address, data} (MSB first), commits writes on nCS release and
//   streams register contents out on CIPO for read frames.
// Ports:
//   clk, rst_n     system clock, asynchronous active-low reset
//   spi            SPI pins (slave modport): nCS, SCLK, COPI in; CIPO, cipo_oe out
//   regs_flat      register contents, register i at [i*DATA_W +: DATA_W]
//   wr_strobe      one-clk pulse per committed write
//   wr_addr        address of the last committed write
//   frame_err_cnt  saturating count of rejected (wrong-length) frames
module spi_regfile_peripheral #(
  parameter int                NUM_REGS  = 5,
  parameter int                ADDR_W    = 7,
  parameter int                DATA_W    = 8,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  spi_regfile_peripheral_if.slave    spi,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat,
  output logic                       wr_strobe,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic [7:0]                 frame_err_cnt
);

  localparam int FRAME_W = 1 + ADDR_W + DATA_W;
  // The counter must hold FRAME_W+1 so over-long frames stay distinguishable.
  localparam int CNT_W   = $clog2(FRAME_W + 2);

  localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0]  CNT_SAT    = CNT_W'(FRAME_W + 1);
  localparam logic [CNT_W-1:0]  CNT_ADDR   = CNT_W'(ADDR_W);
  // One extra bit so NUM_REGS == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0]   NUM_REGS_X = (ADDR_W + 1)'(NUM_REGS);

  // Synchronisers and previous-value flops for edge detection.
  logic ncs_s1, ncs_s2, ncs_q;
  logic sclk_s1, sclk_s2, sclk_q;
  logic copi_s1, copi_s2;

  logic [FRAME_W-1:0] shreg;
  logic [CNT_W-1:0]   cnt;
  logic [DATA_W-1:0]  out_sh;
  logic [DATA_W-1:0]  regs [NUM_REGS];

  logic               sclk_rise, sclk_fall, ncs_rise, active;
  logic [FRAME_W-1:0] shift_next;
  logic               frame_rw;
  logic [ADDR_W-1:0]  frame_addr;
  logic [DATA_W-1:0]  frame_data;
  logic               rd_rw;
  logic [ADDR_W-1:0]  rd_addr;
  logic [DATA_W-1:0]  rd_val;
  logic               do_write;
  logic               frame_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ncs_s1  <= 1'b1;
      ncs_s2  <= 1'b1;
      ncs_q   <= 1'b1;
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_q  <= 1'b0;
      copi_s1 <= 1'b0;
      copi_s2 <= 1'b0;
    end else begin
      ncs_s1  <= spi.nCS;
      ncs_s2  <= ncs_s1;
      ncs_q   <= ncs_s2;
      sclk_s1 <= spi.SCLK;
      sclk_s2 <= sclk_s1;
      sclk_q  <= sclk_s2;
      copi_s1 <= spi.COPI;
      copi_s2 <= copi_s1;
    end
  end

  always_comb begin
    active     = ~ncs_s2;
    sclk_rise  = sclk_s2 & ~sclk_q;
    sclk_fall  = ~sclk_s2 & sclk_q;
    ncs_rise   = ncs_s2 & ~ncs_q;
    shift_next = {shreg[FRAME_W-2:0], copi_s2};

    frame_rw   = shreg[FRAME_W-1];
    frame_addr = shreg[DATA_W +: ADDR_W];
    frame_data = shreg[DATA_W-1:0];

    // Read decode looks at the post-shift view: the edge being processed
    // supplies the address LSB.
    rd_rw   = shift_next[ADDR_W];
    rd_addr = shift_next[ADDR_W-1:0];
    rd_val  = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_addr == ADDR_W'(i)) rd_val = regs[i];
    end

    do_write  = ncs_rise && (cnt == CNT_FULL) && frame_rw &&
                ({1'b0, frame_addr} < NUM_REGS_X);
    frame_bad = ncs_rise && (cnt != '0) && (cnt != CNT_FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg         <= '0;
      cnt           <= '0;
      out_sh        <= '0;
      wr_strobe     <= 1'b0;
      wr_addr       <= '0;
      frame_err_cnt <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
    end else begin
      wr_strobe <= 1'b0;

      if (active) begin
        if (sclk_rise) begin
          shreg <= shift_next;
          if (cnt != CNT_SAT) cnt <= cnt + 1'b1;
          if (cnt == CNT_ADDR && !rd_rw) out_sh <= rd_val;
        end else if (sclk_fall) begin
          // Zero fill: once the LSB has gone out CIPO reads 0.
          out_sh <= {out_sh[DATA_W-2:0], 1'b0};
        end
      end else begin
        cnt    <= '0;
        shreg  <= '0;
        out_sh <= '0;
      end

      // A read load in this same clk sees the pre-write contents because
      // rd_val samples regs before this update lands.
      if (do_write) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (frame_addr == ADDR_W'(i)) regs[i] <= frame_data;
        end
        wr_strobe <= 1'b1;
        wr_addr   <= frame_addr;
      end

      if (frame_bad && frame_err_cnt != 8'hFF) frame_err_cnt <= frame_err_cnt + 8'd1;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_flat[g*DATA_W +: DATA_W] = regs[g];
  end

  assign spi.CIPO    = out_sh[DATA_W-1];
  assign spi.cipo_oe = active;

endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// tb/tb_spi_regfile_peripheral.sv - directed self-checking bench for spi_regfile_peripheral
module tb_spi_regfile_peripheral;

  localparam int HALF = 60;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ncs = 1'b1;
  logic sclk = 1'b0;
  logic copi = 1'b0;
  logic sel = 1'b0;

  int total = 0;
  int bad = 0;
  int stb_a = 0;
  int stb_b = 0;

  always #5 clk = ~clk;

  spi_regfile_peripheral_if bus_a ();
  spi_regfile_peripheral_if bus_b ();

  assign bus_a.nCS  = sel ? 1'b1 : ncs;
  assign bus_a.SCLK = sclk;
  assign bus_a.COPI = copi;
  assign bus_b.nCS  = sel ? ncs : 1'b1;
  assign bus_b.SCLK = sclk;
  assign bus_b.COPI = copi;

  logic [39:0]  regs_a;
  logic         stb_pulse_a;
  logic [6:0]   waddr_a;
  logic [7:0]   err_a;
  logic [255:0] regs_b;
  logic         stb_pulse_b;
  logic [3:0]   waddr_b;
  logic [7:0]   err_b;

  spi_regfile_peripheral dut_a (
    .clk           (clk),
    .rst_n         (rst_n),
    .spi           (bus_a),
    .regs_flat     (regs_a),
    .wr_strobe     (stb_pulse_a),
    .wr_addr       (waddr_a),
    .frame_err_cnt (err_a)
  );

  spi_regfile_peripheral #(
    .NUM_REGS (16),
    .ADDR_W   (4),
    .DATA_W   (16)
  ) dut_b (
    .clk           (clk),
    .rst_n         (rst_n),
    .spi           (bus_b),
    .regs_flat     (regs_b),
    .wr_strobe     (stb_pulse_b),
    .wr_addr       (waddr_b),
    .frame_err_cnt (err_b)
  );

  // Counts clk cycles with the strobe high, so a stretched pulse also shows up.
  always @(posedge clk) begin
    if (stb_pulse_a) stb_a <= stb_a + 1;
    if (stb_pulse_b) stb_b <= stb_b + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drives one frame of nbits, MSB first; samples CIPO late in each SCLK high phase.
  task automatic xfer(input int nbits, input logic [31:0] frame,
                      output logic [31:0] rx, output logic oe_mid);
    logic cipo_now;
    rx = '0;
    oe_mid = 1'b0;
    ncs = 1'b0;
    #(2*HALF);
    for (int i = 0; i < nbits; i++) begin
      copi = frame[nbits-1-i];
      #(HALF);
      sclk = 1'b1;
      #(HALF);
      cipo_now = sel ? bus_b.CIPO : bus_a.CIPO;
      if (i == 0) oe_mid = sel ? bus_b.cipo_oe : bus_a.cipo_oe;
      rx = {rx[30:0], cipo_now};
      sclk = 1'b0;
    end
    #(HALF);
    ncs = 1'b1;
    copi = 1'b0;
    #(100);
  endtask

  initial begin
    logic [31:0] rx;
    logic        oe;

    #23;
    check("rst_regs_a", {24'd0, regs_a}, 64'd0);
    check("rst_stb_a", {63'd0, stb_pulse_a}, 64'd0);
    check("rst_waddr_a", {57'd0, waddr_a}, 64'd0);
    check("rst_err_a", {56'd0, err_a}, 64'd0);
    check("rst_cipo_a", {63'd0, bus_a.CIPO}, 64'd0);
    check("rst_oe_a", {63'd0, bus_a.cipo_oe}, 64'd0);
    check("rst_regs_b", {63'd0, |regs_b}, 64'd0);
    rst_n = 1'b1;
    #100;

    // Write addr 2 = 0x55.
    xfer(16, 32'h8255, rx, oe);
    check("w1_regs", {24'd0, regs_a}, 64'h00_0000_5500_00);
    check("w1_strobe_cycles", 64'(stb_a), 64'd1);
    check("w1_waddr", {57'd0, waddr_a}, 64'd2);
    check("w1_cipo_quiet", {32'd0, rx}, 64'd0);
    check("w1_oe_mid", {63'd0, oe}, 64'd1);

    // Write addr 4 = 0xA5, then read it back.
    xfer(16, 32'h84A5, rx, oe);
    check("w2_regs", {24'd0, regs_a}, 64'h00_00A5_0055_0000);
    xfer(16, 32'h0400, rx, oe);
    check("r4_data", {56'd0, rx[8:1]}, 64'hA5);
    check("r4_pre_zero", {32'd0, rx >> 9}, 64'd0);
    check("r4_post_zero", {63'd0, rx[0]}, 64'd0);
    check("r4_oe_mid", {63'd0, oe}, 64'd1);
    check("r4_oe_idle", {63'd0, bus_a.cipo_oe}, 64'd0);
    check("r4_no_strobe", 64'(stb_a), 64'd2);
    check("r4_err", {56'd0, err_a}, 64'd0);

    // Out-of-range write and read.
    xfer(16, 32'h8711, rx, oe);
    check("w7_regs", {24'd0, regs_a}, 64'h00_00A5_0055_0000);
    check("w7_no_strobe", 64'(stb_a), 64'd2);
    check("w7_err", {56'd0, err_a}, 64'd0);
    check("w7_waddr_kept", {57'd0, waddr_a}, 64'd4);
    xfer(16, 32'h0700, rx, oe);
    check("r7_data", {32'd0, rx}, 64'd0);

    // Wrong-length frames.
    xfer(12, 32'hFFF, rx, oe);
    xfer(17, 32'h1FFFF, rx, oe);
    check("bad_len_regs", {24'd0, regs_a}, 64'h00_00A5_0055_0000);
    check("bad_len_err", {56'd0, err_a}, 64'd2);
    check("bad_len_no_strobe", 64'(stb_a), 64'd2);
    for (int k = 0; k < 300; k++) xfer(1, 32'h1, rx, oe);
    check("err_saturate", {56'd0, err_a}, 64'd255);

    // Widened instance: FRAME_W = 21.
    sel = 1'b1;
    xfer(21, 32'h12BEEF, rx, oe);
    check("b_w2_reg", {48'd0, regs_b[47:32]}, 64'hBEEF);
    check("b_w2_strobe_cycles", 64'(stb_b), 64'd1);
    check("b_w2_waddr", {60'd0, waddr_b}, 64'd2);
    xfer(21, 32'h14A5C3, rx, oe);
    xfer(21, 32'h040000, rx, oe);
    check("b_r4_data", {48'd0, rx[16:1]}, 64'hA5C3);
    check("b_r4_pre_zero", {32'd0, rx >> 17}, 64'd0);
    check("b_r4_post_zero", {63'd0, rx[0]}, 64'd0);
    check("b_others_zero", {63'd0, |{regs_b[255:80], regs_b[63:48], regs_b[31:0]}}, 64'd0);
    check("b_err", {56'd0, err_b}, 64'd0);
    check("a_untouched", {24'd0, regs_a}, 64'h00_00A5_0055_0000);
    sel = 1'b0;

    // Reset in the middle of a write frame to addr 1.
    ncs = 1'b0;
    #(2*HALF);
    for (int i = 0; i < 8; i++) begin
      copi = 1'b1;
      if (i >= 1 && i <= 6) copi = 1'b0;
      #(HALF);
      sclk = 1'b1;
      #(HALF);
      sclk = 1'b0;
    end
    rst_n = 1'b0;
    #30;
    check("mid_rst_regs", {24'd0, regs_a}, 64'd0);
    check("mid_rst_err", {56'd0, err_a}, 64'd0);
    rst_n = 1'b1;
    #(HALF);
    ncs = 1'b1;
    copi = 1'b0;
    #100;
    xfer(16, 32'h8133, rx, oe);
    check("post_rst_regs", {24'd0, regs_a}, 64'h00_0000_0000_3300);
    check("post_rst_waddr", {57'd0, waddr_a}, 64'd1);
    check("post_rst_err", {56'd0, err_a}, 64'd0);
    check("post_rst_b_regs", {63'd0, |regs_b}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
